// File: rtl/data_mem_ctrl.sv
// Load/store front end for a single-port data BRAM: sizing, alignment checks, lane steering, load extension.
// Latency: store/error response 1 cycle after accept, load response RD_LATENCY+1 cycles after accept.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_regce,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t      state;
    logic [1:0]  rd_cnt;
    logic [1:0]  cap_off;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic        accept;
    logic        size_err;
    logic        align_err;
    logic        range_err;
    logic        acc_err;
    logic [31:0] lane_shift;
    logic [31:0] ld_data;

    assign req_ready = (state == IDLE) && !rsta;
    assign accept    = req_valid && req_ready;

    assign size_err  = (req_size == 2'b11);
    assign align_err = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign range_err = |(req_addr >> (ADDR_WIDTH + 2));
    assign acc_err   = size_err || align_err || range_err;

    assign mem_addr  = req_addr[ADDR_WIDTH+1:2];
    assign mem_regce = (state == READ) && !rsta;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_wdata = req_wdata;
        case (req_size)
            2'b00:   mem_wdata = {4{req_wdata[7:0]}};
            2'b01:   mem_wdata = {2{req_wdata[15:0]}};
            default: mem_wdata = req_wdata;
        endcase
        if (accept && !acc_err) begin
            mem_en = 1'b1;
            if (req_we) begin
                case (req_size)
                    2'b00:   mem_we = 4'b0001 << req_addr[1:0];
                    2'b01:   mem_we = req_addr[1] ? 4'b1100 : 4'b0011;
                    default: mem_we = 4'b1111;
                endcase
            end
        end
    end

    // Lane select and extension use the fields captured at accept, not the live request.
    always_comb begin
        lane_shift = mem_rdata >> {cap_off, 3'b000};
        case (cap_size)
            2'b00:   ld_data = {{24{!cap_uns && lane_shift[7]}}, lane_shift[7:0]};
            2'b01:   ld_data = cap_off[1] ? {{16{!cap_uns && mem_rdata[31]}}, mem_rdata[31:16]}
                                          : {{16{!cap_uns && mem_rdata[15]}}, mem_rdata[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state     <= IDLE;
            rd_cnt    <= 2'd0;
            cap_off   <= 2'd0;
            cap_size  <= 2'd0;
            cap_uns   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_off  <= req_addr[1:0];
                        cap_size <= req_size;
                        cap_uns  <= req_unsigned;
                        rd_cnt   <= 2'(RD_LATENCY - 1);
                        if (acc_err || req_we) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= acc_err;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd_cnt == 2'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= ld_data;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Random and directed load/store traffic against two controllers (RD_LATENCY 1 and 2), each with a BRAM model,
// checked against a byte-level memory reference.
module tb_data_mem_ctrl;

    localparam int AW   = 15;
    localparam int MEMW = 1 << AW;

    logic        clka;
    logic        rsta;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];
    logic        mem_en       [2];
    logic [3:0]  mem_we       [2];
    logic [AW-1:0] mem_addr   [2];
    logic [31:0] mem_wdata    [2];
    logic        mem_regce    [2];
    logic [31:0] mem_rdata    [2];

    bit [31:0] ref_mem [2][0:MEMW-1];
    int n_checks = 0;
    int n_fail   = 0;
    int cur_unit = 0;

    initial clka = 1'b0;
    always #5 clka = ~clka;

    function automatic bit [31:0] init_word(input int g, input int i);
        return (32'(i) * 32'h9E3779B1) ^ (32'(g) * 32'h01010101) ^ 32'hC3A55A3C;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_unit
        bit [31:0] mem [0:MEMW-1];
        bit [31:0] lat0;
        bit [31:0] oreg;

        data_mem_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(g + 1)) u_dut (
            .clka        (clka),
            .rsta        (rsta),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_we      (req_we[g]),
            .req_size    (req_size[g]),
            .req_unsigned(req_unsigned[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_rdata   (rsp_rdata[g]),
            .rsp_err     (rsp_err[g]),
            .mem_en      (mem_en[g]),
            .mem_we      (mem_we[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_regce   (mem_regce[g]),
            .mem_rdata   (mem_rdata[g])
        );

        initial begin
            for (int i = 0; i < MEMW; i++) mem[i] <= init_word(g, i);
        end

        always @(posedge clka) begin
            if (mem_en[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
                if (mem_we[g] == 4'b0000) lat0 <= mem[mem_addr[g]];
            end
            if (mem_regce[g]) oreg <= lat0;
        end

        assign mem_rdata[g] = (g == 1) ? oreg : lat0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s unit=%0d got=%h exp=%h t=%0t", tag, cur_unit, got, exp, $time);
        end
    endtask

    // Byte-level memory semantics; stores commit to ref_mem at once.
    function automatic void ref_model(input int u, input bit we, input bit [1:0] sz, input bit uns,
                                      input bit [31:0] a, input bit [31:0] wd,
                                      output bit [31:0] rd, output bit err,
                                      output bit [3:0] wmask, output bit [31:0] wdat);
        int nb;
        int off;
        bit [31:0] w;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off   = int'(a % 4);
        err   = (sz == 2'd3) || ((a % nb) != 0) || ((a >> (AW + 2)) != 0);
        rd    = 0;
        wmask = 0;
        wdat  = 0;
        if (err) return;
        w = ref_mem[u][a / 4];
        for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % nb) +: 8];
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + nb) begin
                    wmask[i]     = 1'b1;
                    w[8*i +: 8]  = wdat[8*i +: 8];
                end
            ref_mem[u][a / 4] = w;
        end else begin
            for (int k = 0; k < nb; k++) rd[8*k +: 8] = w[8*(off + k) +: 8];
            if (!uns && nb < 4 && rd[8*nb - 1])
                for (int k = nb; k < 4; k++) rd[8*k +: 8] = 8'hFF;
        end
    endfunction

    task automatic do_op(input int u, input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd, input int hold,
                         output bit [31:0] got, output bit got_err);
        bit [31:0] e_rd;
        bit [31:0] e_wd;
        bit        e_err;
        bit [3:0]  e_we;
        int        lat;
        int        n;
        int        first;
        int        regce_n;
        bit        en_seen;
        cur_unit = u;
        ref_model(u, we, sz, uns, a, wd, e_rd, e_err, e_we, e_wd);
        lat = (e_err || we) ? 1 : u + 2;
        @(negedge clka);
        req_valid[u] = 1'b1; req_we[u] = we; req_size[u] = sz; req_unsigned[u] = uns;
        req_addr[u] = a; req_wdata[u] = wd; rsp_ready[u] = (hold == 0);
        #1;
        check("acc_req_ready", 32'(req_ready[u]), 32'd1);
        check("acc_mem_en", 32'(mem_en[u]), 32'(!e_err));
        check("acc_mem_we", 32'(mem_we[u]), 32'(e_we));
        if (!e_err) check("acc_mem_addr", 32'(mem_addr[u]), (a >> 2) & (MEMW - 1));
        if (!e_err && we) check("acc_mem_wdata", mem_wdata[u], e_wd);
        @(posedge clka);
        #1;
        req_valid[u] = 1'b0; req_we[u] = 1'($urandom); req_size[u] = 2'($urandom);
        req_addr[u] = $urandom; req_wdata[u] = $urandom; req_unsigned[u] = 1'($urandom);
        n = 0; first = 0; regce_n = 0; en_seen = 0;
        while (first == 0 && n < 12) begin
            @(negedge clka);
            n++;
            if (mem_regce[u]) regce_n++;
            if (mem_en[u] || mem_we[u] != 4'b0000) en_seen = 1'b1;
            if (rsp_valid[u]) first = n;
        end
        got     = rsp_rdata[u];
        got_err = rsp_err[u];
        check("rsp_latency", 32'(first), 32'(lat));
        if (first == 0) return;
        check("rsp_rdata", rsp_rdata[u], e_rd);
        check("rsp_err", 32'(rsp_err[u]), 32'(e_err));
        check("regce_cycles", 32'(regce_n), (!we && !e_err) ? 32'(u + 1) : 32'd0);
        check("mem_idle_after_acc", 32'(en_seen), 32'd0);
        check("resp_req_ready", 32'(req_ready[u]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clka);
            check("hold_valid", 32'(rsp_valid[u]), 32'd1);
            check("hold_rdata", rsp_rdata[u], e_rd);
            check("hold_err", 32'(rsp_err[u]), 32'(e_err));
            check("hold_req_ready", 32'(req_ready[u]), 32'd0);
        end
        rsp_ready[u] = 1'b1;
        req_valid[u] = 1'b1;
        #1;
        check("release_req_ready", 32'(req_ready[u]), 32'd0);
        @(negedge clka);
        req_valid[u] = 1'b0;
        #1;
        check("post_rsp_valid", 32'(rsp_valid[u]), 32'd0);
        check("post_req_ready", 32'(req_ready[u]), 32'd1);
    endtask

    task automatic reset_mid_load(input int u);
        bit seen;
        cur_unit = u;
        @(negedge clka);
        req_valid[u] = 1'b1; req_we[u] = 1'b0; req_size[u] = 2'd2; req_unsigned[u] = 1'b0;
        req_addr[u] = 32'h10; rsp_ready[u] = 1'b1;
        @(posedge clka);
        #1;
        req_valid[u] = 1'b0;
        @(negedge clka);
        rsta = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready[u]), 32'd0);
        check("rst_mem_regce", 32'(mem_regce[u]), 32'd0);
        check("rst_mem_en", 32'(mem_en[u]), 32'd0);
        @(negedge clka);
        check("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
        rsta = 1'b0;
        #1;
        check("rst_idle_ready", 32'(req_ready[u]), 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clka);
            seen |= rsp_valid[u];
        end
        check("rst_no_response", 32'(seen), 32'd0);
    endtask

    task automatic reset_during_store(input int u, input bit [31:0] a, input bit [31:0] d);
        bit [31:0] rd;
        bit [31:0] wdat;
        bit        err;
        bit [3:0]  wm;
        cur_unit = u;
        ref_model(u, 1'b1, 2'd2, 1'b0, a, d, rd, err, wm, wdat);
        @(negedge clka);
        req_valid[u] = 1'b1; req_we[u] = 1'b1; req_size[u] = 2'd2; req_unsigned[u] = 1'b0;
        req_addr[u] = a; req_wdata[u] = d; rsp_ready[u] = 1'b0;
        @(posedge clka);
        #1;
        req_valid[u] = 1'b0;
        @(negedge clka);
        rsta = 1'b1;
        @(negedge clka);
        check("rst_store_rsp_valid", 32'(rsp_valid[u]), 32'd0);
        check("rst_store_rsp_err", 32'(rsp_err[u]), 32'd0);
        rsta = 1'b0;
        rsp_ready[u] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        bit [31:0] got;
        bit        gerr;
        bit        we;
        bit [1:0]  sz;
        bit [31:0] a;
        int        r;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < MEMW; i++) ref_mem[u][i] = init_word(u, i);

        rsta = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b1; req_we[u] = 1'b1; req_size[u] = 2'd2; req_unsigned[u] = 1'b0;
            req_addr[u] = 32'h10; req_wdata[u] = 32'h55AA55AA; rsp_ready[u] = 1'b1;
        end
        repeat (2) @(negedge clka);
        repeat (2) begin
            @(negedge clka);
            for (int u = 0; u < 2; u++) begin
                cur_unit = u;
                check("reset_req_ready", 32'(req_ready[u]), 32'd0);
                check("reset_mem_en", 32'(mem_en[u]), 32'd0);
                check("reset_mem_we", 32'(mem_we[u]), 32'd0);
                check("reset_mem_regce", 32'(mem_regce[u]), 32'd0);
                check("reset_rsp_valid", 32'(rsp_valid[u]), 32'd0);
                check("reset_rsp_rdata", rsp_rdata[u], 32'd0);
                check("reset_rsp_err", 32'(rsp_err[u]), 32'd0);
            end
        end
        rsta = 1'b0;
        for (int u = 0; u < 2; u++) req_valid[u] = 1'b0;

        for (int u = 0; u < 2; u++) begin
            do_op(u, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, got, gerr);
            do_op(u, 0, 2'd2, 0, 32'h10, 32'h0, 0, got, gerr);
            check("lw_deadbeef", got, 32'hDEADBEEF);
            do_op(u, 1, 2'd2, 0, 32'h10, 32'h80FF1234, 0, got, gerr);
            do_op(u, 0, 2'd0, 0, 32'h13, 32'h0, 1, got, gerr);
            check("lb_signed", got, 32'hFFFFFF80);
            do_op(u, 0, 2'd0, 1, 32'h13, 32'h0, 0, got, gerr);
            check("lbu", got, 32'h00000080);
            do_op(u, 1, 2'd2, 0, 32'h20, 32'h11112222, 0, got, gerr);
            do_op(u, 1, 2'd1, 0, 32'h22, 32'h0000ABCD, 0, got, gerr);
            do_op(u, 0, 2'd2, 0, 32'h20, 32'h0, 0, got, gerr);
            check("sh_then_lw", got, 32'hABCD2222);
            do_op(u, 0, 2'd2, 0, 32'h11, 32'h0, 0, got, gerr);
            check("err_lw_misaligned", 32'(gerr), 32'd1);
            do_op(u, 1, 2'd1, 0, 32'h01, 32'h1234, 0, got, gerr);
            check("err_sh_misaligned", 32'(gerr), 32'd1);
            do_op(u, 0, 2'd3, 0, 32'h10, 32'h0, 0, got, gerr);
            check("err_size11", 32'(gerr), 32'd1);
            do_op(u, 0, 2'd2, 0, (32'd1 << (AW + 2)) | 32'h10, 32'h0, 0, got, gerr);
            check("err_range", 32'(gerr), 32'd1);
            check("err_range_rdata", got, 32'd0);
            do_op(u, 0, 2'd2, 0, 32'h10, 32'h0, 5, got, gerr);
            check("backpressure_lw", got, 32'h80FF1234);
            reset_mid_load(u);
            reset_during_store(u, 32'h30, 32'hCAFEF00D);
            do_op(u, 0, 2'd2, 0, 32'h30, 32'h0, 0, got, gerr);
            check("store_survives_reset", got, 32'hCAFEF00D);
        end

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 150; i++) begin
                we = 1'($urandom_range(0, 1));
                r  = $urandom_range(0, 15);
                sz = (r == 0) ? 2'd3 : 2'(r % 3);
                a  = $urandom_range(0, 255);
                if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
                if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
                do_op(u, we, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), got, gerr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 15, word-address width of the data BRAM port.
- RD_LATENCY, 1, BRAM read latency in cycles (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE); any other value is illegal.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clka, in, 1, single clock; all logic on its rising edge.
- rsta, in, 1, reset; synchronous, active-high.
- req_valid, in, 1, core request valid.
- req_ready, out, 1, block accepts a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_size, in, 2, 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned, in, 1, load zero-extend (LBU/LHU).
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, right-aligned.
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, core accepts the response.
- rsp_rdata, out, 32, load result, extended.
- rsp_err, out, 1, misaligned, illegal or out-of-range access.
- mem_en, out, 1, BRAM port enable.
- mem_we, out, 4, BRAM byte write enables.
- mem_addr, out, ADDR_WIDTH, BRAM word address = req_addr[ADDR_WIDTH+1:2].
- mem_wdata, out, 32, BRAM write data.
- mem_regce, out, 1, BRAM output register enable.
- mem_rdata, in, 32, BRAM read data.

Function
REQ-003 FSM SHALL have states IDLE, READ, RESP; req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready.
REQ-004 Error on accept SHALL be any of:
- req_size = 11;
- half-word access with addr[0] = 1;
- word access with addr[1:0] != 0;
- req_addr[31:ADDR_WIDTH+2] != 0.
REQ-005 On an erroring accept: mem_en = 0, no BRAM access; next state RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-006 Store accept SHALL drive, combinationally in the accept cycle:
- mem_en = 1;
- mem_we: byte = 4'b0001 << addr[1:0]; half = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); word = 1111;
- mem_wdata: byte = wdata[7:0] replicated x4; half = wdata[15:0] replicated x2; word = wdata.
- Next state RESP with rsp_err = 0 and rsp_rdata = 0.
REQ-007 Load accept SHALL drive mem_en = 1 and mem_we = 0, then enter READ.
REQ-008 READ SHALL last RD_LATENCY cycles.
- mem_regce = 1 in every READ cycle; mem_en = 0 in READ.
- In the last READ cycle, the extracted mem_rdata SHALL be registered into rsp_rdata; next state RESP.
REQ-009 Load extraction SHALL be:
- byte = lane addr[1:0];
- half = lane addr[1];
- each extended to 32 bits, sign-extended unless req_unsigned is set;
- addr[1:0], size and unsigned SHALL be registered at accept.
REQ-010 Latency from the accept edge to rsp_valid high SHALL be:
- 1 cycle for stores and errors;
- RD_LATENCY+1 cycles for loads.
REQ-011 In RESP, rsp_valid = 1 and rsp_rdata / rsp_err SHALL hold stable until rsp_ready = 1; that cycle returns to IDLE.
- A new request SHALL NOT be accepted in the same cycle.
REQ-012 Outside accept and READ cycles: mem_en = 0, mem_we = 0, mem_regce = 0.
REQ-013 Inputs SHALL be ignored in READ and RESP; req_* need not stay stable after accept.

Reset
REQ-014 rsta = 1 at a clock edge SHALL force state IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and clear all captured request fields.
REQ-015 While rsta = 1: req_ready = 0, mem_en = 0, mem_we = 0, mem_regce = 0.
REQ-016 Reset in READ or RESP SHALL discard the pending response.
- A store driven in an earlier accept cycle remains committed in the BRAM.

Verification
REQ-017 Word store then load: SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_we = 1111, mem_addr = 4; load rsp_rdata = 0xDEADBEEF, rsp_valid 2 cycles after accept (RD_LATENCY = 1).
REQ-018 Byte load: LB @0x13, then LBU @0x13, with the word holding 0x80FF1234 -> mem_we = 0; rsp_rdata = 0xFFFFFF80, then 0x00000080.
REQ-019 Half store: SH 0xABCD @0x22 -> mem_we = 1100, mem_wdata = 0xABCDABCD; a following LW @0x20 returns 0xABCD in [31:16], with [15:0] unchanged.
REQ-020 Errors: LW @0x11, SH @0x01, size = 11, and an address with bit ADDR_WIDTH+2 set -> each gives mem_en = 0 throughout, rsp_err = 1, rsp_rdata = 0.
REQ-021 Backpressure and latency: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0; with RD_LATENCY = 2 a load responds 3 cycles after accept, with mem_regce high for 2 cycles.
REQ-022 Reset mid-load: rsta asserted in READ -> the next cycle is IDLE with rsp_valid = 0 and req_ready = 1 after rsta drops; no response is emitted.
